uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Synchronous transmit FIFO that buffers bytes written by the APB register interface and feeds the UART transmitter when that transmitter is built with its TX FIFO option enabled. It supplies `dout`, `empty` and `full` to the transmitter and accepts its active-low read strobe, so the transmitter can pop one byte per frame with no extra glue logic. It also reports occupancy and a sticky overflow flag to the status register.

## Interface
- `DEPTH`, default 16: number of entries. Must be a power of two in the range 2..256.
- `WIDTH`, default 8: data width in bits.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `din`  in  WIDTH  write data from the APB TX holding register.
- `wr_n`  in  1  write strobe, active-low. Sampled once per cycle.
- `rd_n`  in  1  read strobe, active-low. Driven by the transmitter's FIFO read output.
- `clr_ovf`  in  1  synchronous clear of `overflow`. Active-high.
- `dout`  out  WIDTH  registered read data.
- `empty`  out  1  high when the FIFO holds 0 entries.
- `full`  out  1  high when the FIFO holds DEPTH entries.
- `level`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow`  out  1  sticky flag: a write was attempted while the FIFO was full.

## Operation
- Storage is DEPTH x WIDTH, addressed by write pointer `wp` and read pointer `rp`. Each pointer is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
- Accepted write: `!wr_n && !full`. Stores `din` at `wp`, then increments `wp`.
- Accepted read: `!rd_n && !empty`. Loads `mem[rp]` into `dout`, then increments `rp`.
- `level`:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle, or neither is.
- Boundary cases:
  - Write while full, with no read in the same cycle: the data is dropped, pointers and level are unchanged, `overflow` is set.
  - Write and read together while full: both are accepted, level stays DEPTH, no overflow.
  - Read while empty: ignored, `dout` holds its value.
  - Write and read together while empty: only the write is accepted. `dout` is not updated (no fall-through). Level goes to 1.
- `overflow` stays high until `clr_ovf` is asserted. If `clr_ovf` and a new overflow occur in the same cycle, set takes priority.
- `dout` holds its last value between reads.
- Reset mid-operation discards all contents immediately. Memory contents are not reset; they are don't-care.

## Timing
- Values after reset: `dout`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0, `wp`=`rp`=0.
- Read latency: `dout` is valid on the clock edge that samples an accepted `rd_n` low, and is visible from the following cycle. This satisfies the transmitter, which latches the byte at its start-bit state, at least two cycles after the strobe.
- Flags: `empty`, `full` and `level` are registered. They reflect the result of the accepted operations from the same edge, so there is one cycle of flag latency after a strobe.
- Write-to-read: a byte written at edge N can be read at edge N+1 at the earliest, once `empty` has dropped.
- Strobe width: a strobe held low for k cycles performs up to k operations. The transmitter pulses `rd_n` low for exactly one cycle per frame.

## Structure
- Shared package `uart_pkg`:
  - Constants `UART_FIFO_DEPTH_DEF`=16 and `UART_DATA_W`=8.
  - Function `clog2_f` for computing pointer and level widths.
- Sub-module `uart_fifo_ram`: simple dual-port array with a synchronous write port and a registered read port.
  - Kept separate so it can map to a vendor RAM block.
  - Pointers, flags, level and overflow stay in the top-level control logic.

## Test plan
- **Reset:** assert `aresetn` low mid-stream after 5 writes. Expect `empty`=1, `level`=0 and `dout`=0 immediately; a subsequent read has no effect.
- **Fill and drain, DEPTH=16:** write 0x00..0x0F.
  - `full` rises the cycle after the 16th write; `level`=16.
  - Sixteen single-cycle reads return 0x00..0x0F in order.
  - `empty` rises after the last read.
- **Overflow:** with the FIFO full, write 0xAA. Expect `overflow`=1, `level` still 16, and 0xAA never read out. Pulse `clr_ovf`; expect `overflow`=0.
- **Simultaneous operations:**
  - Full, write 0x55 and read together: old head is read, `level`=16, 0x55 appears last.
  - Empty, write and read together: `dout` unchanged, `level`=1.
- **Wrap-around:** run 40 bytes through in bursts of 3 writes and 2 reads. Expect data order preserved across pointer wrap, and `level` to match a reference count every cycle.
- **Transmitter integration:** connect to the transmitter with TX_FIFO=1 and write 0x41, 0x42. The serial line carries both frames in order, and each `rd_n` pulse is one cycle long.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared constants and helper function for the UART TX FIFO slice.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default FIFO depth and data width used across the UART.
  localparam int UART_FIFO_DEPTH_DEF = 16;
  localparam int UART_DATA_W         = 8;

  // Ceiling log2, usable in constant expressions for pointer/level widths.
  // clog2_f(1) = 0, clog2_f(16) = 4, clog2_f(17) = 5.
  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_ram
//  Brief    : Simple dual-port array: synchronous write port, registered read
//             port with enable. Read-during-write to the same address returns
//             the old contents, which the FIFO relies on when full.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: storage is intentionally not reset so it can map to a RAM block.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port: output register loads only on an enabled read and holds otherwise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule : uart_fifo_ram
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Transmit FIFO between the APB TX holding register and the UART
//             transmitter. Registered dout/flags/level, sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH_DEF,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [WIDTH-1:0]                din,
  input  logic                            wr_n,
  input  logic                            rd_n,
  input  logic                            clr_ovf,
  output logic [WIDTH-1:0]                dout,
  output logic                            empty,
  output logic                            full,
  output logic [clog2_f(DEPTH+1)-1:0]     level,
  output logic                            overflow
);

  localparam int c_ptr_w = clog2_f(DEPTH);
  localparam int c_lvl_w = clog2_f(DEPTH + 1);
  localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(DEPTH);

  logic [c_ptr_w-1:0] r_wp;
  logic [c_ptr_w-1:0] r_rp;
  logic [c_lvl_w-1:0] r_level;
  logic               r_empty;
  logic               r_full;
  logic               r_overflow;

  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_ovf_set;
  logic [c_lvl_w-1:0] w_level_nxt;

  // Accept logic: a write into a full FIFO is still accepted when a read frees
  // the head slot in the same cycle; the RAM returns the old head in that case.
  always_comb begin
    w_rd_acc  = !rd_n && !r_empty;
    w_wr_acc  = !wr_n && (!r_full || w_rd_acc);
    w_ovf_set = !wr_n && r_full && !w_rd_acc;
  end

  // Next occupancy: unchanged when both or neither operation is accepted.
  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + c_lvl_w'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_nxt = r_level - c_lvl_w'(1);
    end
  end

  // Pointers, occupancy and registered flags; pointers wrap naturally.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wp <= r_wp + c_ptr_w'(1);
      end
      if (w_rd_acc) begin
        r_rp <= r_rp + c_ptr_w'(1);
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == c_full_lvl);
    end
  end

  // Sticky overflow: a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (c_ptr_w)
  ) u_ram (
    .clk     (clk),
    .aresetn (aresetn),
    .we      (w_wr_acc),
    .waddr   (r_wp),
    .wdata   (din),
    .re      (w_rd_acc),
    .raddr   (r_rp),
    .rdata   (dout)
  );

  assign empty    = r_empty;
  assign full     = r_full;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed self-checking bench for uart_tx_fifo (DEPTH=16, WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk;
  logic       aresetn;
  logic [7:0] din;
  logic       wr_n;
  logic       rd_n;
  logic       clr_ovf;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overflow;

  int checks;
  int errors;

  uart_tx_fifo #(
    .DEPTH (16),
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .din      (din),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .clr_ovf  (clr_ovf),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d);
    din  = d;
    wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
  endtask

  task automatic do_read();
    rd_n = 1'b0;
    tick();
    rd_n = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    checks++;
    if ({dout, empty, full, level, overflow} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: dout=%h empty=%b full=%b level=%0d ovf=%b, want 00 1 0 0 0",
               dout, empty, full, level, overflow);
    end
    for (int i = 0; i < 5; i++) do_write(8'hC0 + 8'(i));
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL reset_prefill_level: got %0d want 5", level);
    end
    do_read();
    // Mid-cycle asynchronous reset: outputs must clear without a clock edge.
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({dout, empty, level} !== {8'h00, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset_async: dout=%h empty=%b level=%0d, want 00 1 0", dout, empty, level);
    end
    tick();
    aresetn = 1'b1;
    tick();
    do_read();
    checks++;
    if ({dout, empty, level} !== {8'h00, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset_read_after: dout=%h empty=%b level=%0d, want 00 1 0", dout, empty, level);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 15; i++) do_write(8'(i));
    checks++;
    if (full !== 1'b0 || level !== 5'd15) begin
      errors++;
      $display("FAIL fill_15: full=%b level=%0d, want 0 15", full, level);
    end
    do_write(8'h0F);
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_16: full=%b level=%0d empty=%b, want 1 16 0", full, level, empty);
    end
    for (int i = 0; i < 16; i++) begin
      do_read();
      checks++;
      if (dout !== 8'(i)) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h want %h", i, dout, 8'(i));
      end
      if (i == 14) begin
        checks++;
        if (empty !== 1'b0 || level !== 5'd1) begin
          errors++;
          $display("FAIL drain_15: empty=%b level=%0d, want 0 1", empty, level);
        end
      end
    end
    checks++;
    if (empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b level=%0d full=%b, want 1 0 0", empty, level, full);
    end
  endtask

  task automatic test_overflow_and_simultaneous();
    for (int i = 0; i < 16; i++) do_write(8'h10 + 8'(i));
    do_write(8'hAA);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b level=%0d full=%b, want 1 16 1", overflow, level, full);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    // Set beats clear in the same cycle.
    din = 8'hAB; wr_n = 1'b0; clr_ovf = 1'b1;
    tick();
    wr_n = 1'b1; clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_priority: ovf=%b level=%0d, want 1 16", overflow, level);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    // Full: write and read together, both accepted, no overflow.
    din = 8'h55; wr_n = 1'b0; rd_n = 1'b0;
    tick();
    wr_n = 1'b1; rd_n = 1'b1;
    checks++;
    if (dout !== 8'h10 || level !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_rw: dout=%h level=%0d ovf=%b full=%b, want 10 16 0 1",
               dout, level, overflow, full);
    end
    for (int i = 0; i < 16; i++) begin
      do_read();
      checks++;
      if (dout !== ((i == 15) ? 8'h55 : 8'h11 + 8'(i))) begin
        errors++;
        $display("FAIL full_rw_drain[%0d]: got %h want %h", i, dout,
                 (i == 15) ? 8'h55 : 8'h11 + 8'(i));
      end
    end
    // Empty: write and read together, only the write is accepted.
    din = 8'h66; wr_n = 1'b0; rd_n = 1'b0;
    tick();
    wr_n = 1'b1; rd_n = 1'b1;
    checks++;
    if (dout !== 8'h55 || level !== 5'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: dout=%h level=%0d empty=%b, want 55 1 0", dout, level, empty);
    end
    do_read();
    checks++;
    if (dout !== 8'h66 || level !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_read: dout=%h level=%0d empty=%b, want 66 0 1", dout, level, empty);
    end
    // Read while empty leaves dout alone.
    do_read();
    checks++;
    if (dout !== 8'h66 || level !== 5'd0) begin
      errors++;
      $display("FAIL empty_read: dout=%h level=%0d, want 66 0", dout, level);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp;
    int         sent;
    sent = 0;
    while (sent < 40 || q.size() > 0) begin
      for (int w = 0; w < 3 && sent < 40; w++) begin
        do_write(8'h80 + 8'(sent));
        q.push_back(8'h80 + 8'(sent));
        sent++;
        checks++;
        if (level !== 5'(q.size())) begin
          errors++;
          $display("FAIL wrap_level_wr: got %0d want %0d", level, q.size());
        end
      end
      for (int r = 0; r < ((sent < 40) ? 2 : 16) && q.size() > 0; r++) begin
        do_read();
        exp = q.pop_front();
        checks++;
        if (dout !== exp || level !== 5'(q.size())) begin
          errors++;
          $display("FAIL wrap_read: dout=%h level=%0d, want %h %0d", dout, level, exp, q.size());
        end
      end
    end
  endtask

  // Mimics the transmitter: one-cycle rd_n pulse per frame, byte latched
  // two cycles later at its start-bit state.
  task automatic test_tx_integration();
    logic [7:0] expv [2];
    int         frames;
    expv[0] = 8'h41;
    expv[1] = 8'h42;
    frames  = 0;
    do_write(8'h41);
    do_write(8'h42);
    for (int f = 0; f < 6 && !empty; f++) begin
      do_read();
      tick();
      tick();
      checks++;
      if (frames > 1 || dout !== expv[frames]) begin
        errors++;
        $display("FAIL tx_frame[%0d]: got %h want %h", frames, dout, (frames > 1) ? 8'hxx : expv[frames]);
      end
      frames++;
    end
    checks++;
    if (frames !== 2 || empty !== 1'b1) begin
      errors++;
      $display("FAIL tx_frame_count: frames=%0d empty=%b, want 2 1", frames, empty);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    aresetn = 1'b0;
    din     = 8'h00;
    wr_n    = 1'b1;
    rd_n    = 1'b1;
    clr_ovf = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow_and_simultaneous();
    test_wrap();
    test_tx_integration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
